// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 encodings: icodes, ALU ops, stat codes, condition codes
package y86_pkg;

    localparam int W = 64;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_t;

    localparam logic [1:0] SAOK = 2'b00;
    localparam logic [1:0] SHLT = 2'b01;
    localparam logic [1:0] SADR = 2'b10;
    localparam logic [1:0] SINS = 2'b11;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational add/sub/and/xor ALU with signed overflow and zero flags
module alu64
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   fun,
    output logic [W-1:0] c,
    output logic         of,
    output logic         zf
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;

    assign sum  = a + b;
    // Y86 subtracts the first operand from the second
    assign diff = b - a;

    always_comb begin
        c  = sum;
        of = 1'b0;
        case (alu_op_t'(fun))
            ALU_ADD: begin
                c  = sum;
                of = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                c  = diff;
                of = (a[W-1] != b[W-1]) && (diff[W-1] != b[W-1]);
            end
            ALU_AND: c = a & b;
            ALU_XOR: c = a ^ b;
            default: ;
        endcase
    end

    assign zf = (c == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: ALU, CC register, Cnd, M pipeline register
// Optional EXEC_PERF_CNT_EN adds perf_insn_cnt, counting non-nop M register loads.
module execute_stage
    import y86_pkg::*;
#(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [W-1:0] E_valC,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [1:0]   m_stat,
    input  logic [1:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [1:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
`ifdef EXEC_PERF_CNT_EN
    ,output logic [31:0] perf_insn_cnt
`endif
);

    logic [W-1:0] alua;
    logic [W-1:0] alub;
    logic [1:0]   alufun;
    logic         alu_of;
    logic         alu_zf;
    logic         set_cc;
    logic         zf, sf, of;
    logic         sxo;

    always_comb begin
        alua = '0;
        case (E_icode)
            IRRMOVQ, IOPQ:            alua = E_valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alua = E_valC;
            ICALL, IPUSHQ:            alua = {{(W-4){1'b1}}, 4'h8};
            IRET, IPOPQ:              alua = W'(8);
            default: ;
        endcase
    end

    always_comb begin
        alub = '0;
        case (E_icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alub = E_valB;
            default: ;
        endcase
    end

    assign alufun = (E_icode == IOPQ) ? E_ifun[1:0] : ALU_ADD;

    alu64 #(.W(W)) u_alu (
        .a   (alua),
        .b   (alub),
        .fun (alufun),
        .c   (e_valE),
        .of  (alu_of),
        .zf  (alu_zf)
    );

    // Downstream exceptions must not leak flag updates from younger OPq instructions
    assign set_cc = (E_icode == IOPQ) && (m_stat == SAOK) && (W_stat == SAOK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (set_cc) begin
            zf <= alu_zf;
            sf <= e_valE[W-1];
            of <= alu_of;
        end
    end

    assign sxo = sf ^ of;

    always_comb begin
        e_Cnd = 1'b0;
        case (E_ifun)
            C_YES: e_Cnd = 1'b1;
            C_LE:  e_Cnd = sxo | zf;
            C_L:   e_Cnd = sxo;
            C_E:   e_Cnd = zf;
            C_NE:  e_Cnd = ~zf;
            C_GE:  e_Cnd = ~sxo;
            C_G:   e_Cnd = ~sxo & ~zf;
            default: ;
        endcase
    end

    assign e_dstE = ((E_icode == IRRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || M_bubble) begin
            M_stat  <= SAOK;
            M_icode <= INOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_insn_cnt <= '0;
        end else if (!M_bubble && !M_stall && (E_icode != INOP)) begin
            perf_insn_cnt <= perf_insn_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage with a reference ALU/CC model
module tb_execute_stage;

    typedef logic [142:0] mvec_t;
    localparam mvec_t BUBBLE = {2'b00, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};

    logic        clk;
    logic        rst;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valA, E_valB, E_valC;
    logic [3:0]  E_dstE, E_dstM;
    logic [1:0]  m_stat, W_stat;
    logic        M_stall, M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_insn_cnt;
`endif

    execute_stage dut (
        .clk      (clk),
        .rst      (rst),
        .E_stat   (E_stat),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_valC   (E_valC),
        .E_dstE   (E_dstE),
        .E_dstM   (E_dstM),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .M_stall  (M_stall),
        .M_bubble (M_bubble),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .e_Cnd    (e_Cnd),
        .M_stat   (M_stat),
        .M_icode  (M_icode),
        .M_Cnd    (M_Cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM)
`ifdef EXEC_PERF_CNT_EN
        ,.perf_insn_cnt (perf_insn_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model state
    logic        mzf = 1'b1, msf = 1'b0, mof = 1'b0;
    logic        pend_set = 1'b0, pzf, psf, pof;
    logic        pend_cnt = 1'b0;
    int unsigned mcnt = 0;
    logic [63:0] x_valE;
    logic        x_cnd;
    logic [3:0]  x_dstE;
    mvec_t       lastrec = BUBBLE;
    mvec_t       sb[$];
    mvec_t       e;

    function automatic mvec_t m_now();
        return {M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM};
    endfunction

    function automatic logic exp_cnd(input logic [3:0] f, input logic z, input logic s, input logic o);
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return (s ^ o) | z;
            4'd2:    return s ^ o;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !(s ^ o);
            4'd6:    return !(s ^ o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [1:0] ms, input logic [1:0] ws,
                         input logic stall, input logic bub);
        logic [63:0] a, b;
        logic [1:0]  f;
        logic [64:0] wide;
        logic        ov;
        mvec_t       rec;
        E_stat = st; E_icode = ic; E_ifun = fn;
        E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = dm; m_stat = ms; W_stat = ws;
        M_stall = stall; M_bubble = bub;
        case (ic)
            4'h2, 4'h6:       a = va;
            4'h3, 4'h4, 4'h5: a = vc;
            4'h8, 4'hA:       a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'h9, 4'hB:       a = 64'd8;
            default:          a = 64'd0;
        endcase
        b = (ic >= 4'h4 && ic <= 4'hB && ic != 4'h7) ? vb : 64'd0;
        f = (ic == 4'h6) ? fn[1:0] : 2'b00;
        ov = 1'b0;
        case (f)
            2'b00: begin wide = {a[63], a} + {b[63], b}; x_valE = wide[63:0]; ov = wide[64] ^ wide[63]; end
            2'b01: begin wide = {b[63], b} - {a[63], a}; x_valE = wide[63:0]; ov = wide[64] ^ wide[63]; end
            2'b10: x_valE = a & b;
            default: x_valE = a ^ b;
        endcase
        x_cnd  = exp_cnd(fn, mzf, msf, mof);
        x_dstE = (ic == 4'h2 && !x_cnd) ? 4'hF : de;
        pend_set = (ic == 4'h6) && (ms == 2'b00) && (ws == 2'b00);
        pzf = (x_valE == 64'd0); psf = x_valE[63]; pof = ov;
        pend_cnt = !stall && !bub && (ic != 4'h1);
        if (bub)        rec = BUBBLE;
        else if (stall) rec = lastrec;
        else            rec = {st, ic, x_cnd, x_valE, va, x_dstE, dm};
        lastrec = rec;
        sb.push_back(rec);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pend_set) begin
            mzf = pzf; msf = psf; mof = pof;
        end
        if (pend_cnt) mcnt++;
        pend_set = 1'b0;
        pend_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        E_stat = 2'b00; E_icode = 4'h7; E_ifun = 4'h3;
        E_valA = '0; E_valB = '0; E_valC = '0; E_dstE = 4'hF; E_dstM = 4'hF;
        m_stat = 2'b00; W_stat = 2'b00; M_stall = 1'b0; M_bubble = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (m_now() !== BUBBLE) $display("FAIL reset_m: got %h want %h", m_now(), BUBBLE); else pass_cnt++;
        total_cnt++;
        if (e_Cnd !== 1'b1) $display("FAIL reset_zf: e_Cnd(e) got %b want 1", e_Cnd); else pass_cnt++;
        E_ifun = 4'h2; #1;
        total_cnt++;
        if (e_Cnd !== 1'b0) $display("FAIL reset_sfof: e_Cnd(l) got %b want 0", e_Cnd); else pass_cnt++;
        E_ifun = 4'h1; #1;
        total_cnt++;
        if (e_Cnd !== 1'b1) $display("FAIL reset_le: e_Cnd(le) got %b want 1", e_Cnd); else pass_cnt++;
        rst = 1'b0;
        lastrec = BUBBLE;
    endtask

    task automatic test_opq_and();
        issue(2'b00, 4'h6, 4'h2, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'h3, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_valE !== 64'hFFFF_FFFF_FFFF_FFF0) $display("FAIL and_valE: got %h want fffffffffffffff0", e_valE); else pass_cnt++;
        total_cnt++;
        if (e_Cnd !== x_cnd) $display("FAIL and_cnd: got %b want %b", e_Cnd, x_cnd); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL and_m: got %h want %h", m_now(), e); else pass_cnt++;
        issue(2'b00, 4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_Cnd !== 1'b1) $display("FAIL and_sf: jl got %b want 1", e_Cnd); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL and_jl_m: got %h want %h", m_now(), e); else pass_cnt++;
        issue(2'b00, 4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_Cnd !== 1'b0) $display("FAIL and_zf: je got %b want 0", e_Cnd); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL and_je_m: got %h want %h", m_now(), e); else pass_cnt++;
    endtask

    task automatic test_add_overflow();
        issue(2'b00, 4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0, 4'h4, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_valE !== 64'h8000_0000_0000_0000) $display("FAIL add_valE: got %h want 8000000000000000", e_valE); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL add_m: got %h want %h", m_now(), e); else pass_cnt++;
        issue(2'b00, 4'h2, 4'h2, 64'h1234, 64'h9999, 64'h0, 4'h5, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_Cnd !== 1'b0) $display("FAIL cmovl_cnd: got %b want 0", e_Cnd); else pass_cnt++;
        total_cnt++;
        if (e_dstE !== 4'hF) $display("FAIL cmovl_dstE: got %h want f", e_dstE); else pass_cnt++;
        total_cnt++;
        if (e_valE !== 64'h1234) $display("FAIL cmovl_valE: got %h want 1234", e_valE); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL cmovl_m: got %h want %h", m_now(), e); else pass_cnt++;
    endtask

    task automatic test_sub_jne();
        issue(2'b00, 4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h6, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_valE !== 64'd0) $display("FAIL sub_valE: got %h want 0", e_valE); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL sub_m: got %h want %h", m_now(), e); else pass_cnt++;
        issue(2'b00, 4'h7, 4'h4, 64'h0, 64'h0, 64'h80, 4'hF, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_Cnd !== 1'b0) $display("FAIL jne_cnd: got %b want 0", e_Cnd); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL jne_m: got %h want %h", m_now(), e); else pass_cnt++;
        total_cnt++;
        if (M_Cnd !== 1'b0) $display("FAIL jne_M_Cnd: got %b want 0", M_Cnd); else pass_cnt++;
    endtask

    task automatic test_cc_suppress();
        issue(2'b00, 4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h7, 4'hF, 2'b10, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_valE !== 64'd3) $display("FAIL sup_valE: got %h want 3", e_valE); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL sup_m: got %h want %h", m_now(), e); else pass_cnt++;
        issue(2'b00, 4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h7, 4'hF, 2'b00, 2'b01, 1'b0, 1'b0);
        total_cnt++;
        if (e_Cnd !== 1'b1) $display("FAIL sup_mstat_zf: e_Cnd(add) got %b want 1", e_Cnd); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL sup_w_m: got %h want %h", m_now(), e); else pass_cnt++;
        issue(2'b00, 4'hA, 4'h0, 64'h55, 64'h100, 64'h0, 4'h4, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_valE !== 64'hF8) $display("FAIL push_valE: got %h want f8", e_valE); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL push_m: got %h want %h", m_now(), e); else pass_cnt++;
        issue(2'b00, 4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_Cnd !== 1'b1) $display("FAIL sup_zf_kept: je got %b want 1", e_Cnd); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL sup_je_m: got %h want %h", m_now(), e); else pass_cnt++;
    endtask

    task automatic test_stall();
        issue(2'b00, 4'h6, 4'h3, 64'hF0F0, 64'h0FF0, 64'h0, 4'h2, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        total_cnt++;
        if (e_valE !== 64'hFF00) $display("FAIL xor_valE: got %h want ff00", e_valE); else pass_cnt++;
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL xor_m: got %h want %h", m_now(), e); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            issue(2'b01, 4'h5, 4'h0, 64'hAAAA + 64'(i), 64'h1000, 64'h10, 4'hF, 4'h3, 2'b00, 2'b00, 1'b1, 1'b0);
            tick();
            e = sb.pop_front(); total_cnt++;
            if (m_now() !== e) $display("FAIL stall_m%0d: got %h want %h", i, m_now(), e); else pass_cnt++;
        end
        total_cnt++;
        if (M_valE !== 64'hFF00) $display("FAIL stall_valE: got %h want ff00", M_valE); else pass_cnt++;
    endtask

    task automatic test_stall_bubble();
        issue(2'b00, 4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h1, 4'h2, 2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL stallbub_m: got %h want %h", m_now(), e); else pass_cnt++;
        total_cnt++;
        if (M_icode !== 4'h1) $display("FAIL stallbub_icode: got %h want 1", M_icode); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ic, fn, de, dm;
        logic [63:0] va, vb, vc;
        logic [1:0]  st, ms, ws;
        logic        stl, bub;
        for (int i = 0; i < 24; i++) begin
            ic = 4'($urandom_range(0, 11));
            if (ic == 4'h6)                    fn = 4'($urandom_range(0, 3));
            else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 7));
            else                               fn = 4'h0;
            va = {$urandom, $urandom}; vb = {$urandom, $urandom}; vc = {$urandom, $urandom};
            if (i % 4 == 0) vb = va;
            st  = 2'($urandom_range(0, 3));
            ms  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ws  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            stl = ($urandom_range(0, 7) == 0);
            bub = ($urandom_range(0, 7) == 0);
            de  = 4'($urandom_range(0, 15));
            dm  = 4'($urandom_range(0, 15));
            issue(st, ic, fn, va, vb, vc, de, dm, ms, ws, stl, bub);
            total_cnt++;
            if (e_valE !== x_valE) $display("FAIL b2b_valE[%0d]: got %h want %h", i, e_valE, x_valE); else pass_cnt++;
            total_cnt++;
            if (e_Cnd !== x_cnd) $display("FAIL b2b_cnd[%0d]: got %b want %b", i, e_Cnd, x_cnd); else pass_cnt++;
            total_cnt++;
            if (e_dstE !== x_dstE) $display("FAIL b2b_dstE[%0d]: got %h want %h", i, e_dstE, x_dstE); else pass_cnt++;
            tick();
            e = sb.pop_front(); total_cnt++;
            if (m_now() !== e) $display("FAIL b2b_m[%0d]: got %h want %h", i, m_now(), e); else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        issue(2'b00, 4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h3, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); total_cnt++;
        if (m_now() !== e) $display("FAIL mid_pre_m: got %h want %h", m_now(), e); else pass_cnt++;
        E_icode = 4'h7; E_ifun = 4'h3; #1;
        total_cnt++;
        if (e_Cnd !== 1'b0) $display("FAIL mid_pre_zf: je got %b want 0", e_Cnd); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (m_now() !== BUBBLE) $display("FAIL mid_rst_m: got %h want %h", m_now(), BUBBLE); else pass_cnt++;
        total_cnt++;
        if (e_Cnd !== 1'b1) $display("FAIL mid_rst_cc: je got %b want 1", e_Cnd); else pass_cnt++;
        rst = 1'b0;
        mzf = 1'b1; msf = 1'b0; mof = 1'b0;
        lastrec = BUBBLE; mcnt = 0; sb.delete();
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, (i == 1) ? 4'h1 : 4'h3, 4'h0, 64'h0, 64'h0, 64'(100 + i), 4'h8, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0);
            tick();
            e = sb.pop_front(); total_cnt++;
            if (m_now() !== e) $display("FAIL mid_post_m%0d: got %h want %h", i, m_now(), e); else pass_cnt++;
        end
`ifdef EXEC_PERF_CNT_EN
        total_cnt++;
        if (perf_insn_cnt !== 32'(mcnt)) $display("FAIL perf_cnt: got %0d want %0d", perf_insn_cnt, mcnt); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_opq_and();
        test_add_overflow();
        test_sub_jne();
        test_cc_suppress();
        test_stall();
        test_stall_bubble();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
